// File: rtl/radix4_divider.sv
// radix4_divider: iterative unsigned divider, 2 quotient bits per cycle; optional DIV_FAST_PATH_EN skips CALC when dividend < divisor
module radix4_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             busy,
  output logic             done
);
  localparam int ITER = WIDTH / 2;
  localparam int CW = $clog2(ITER + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH+1:0] d1, d2, d3, r, t, sub;
  logic [1:0] dig;
  logic [CW-1:0] cnt;
  logic zero, fast;
  assign zero = divisor == '0;
`ifdef DIV_FAST_PATH_EN
  assign fast = dividend < divisor;
`else
  assign fast = 1'b0;
`endif
  assign busy = state == CALC;
  assign done = state == DONE;
  assign remainder = r[WIDTH-1:0];
  always_comb begin
    t = (r << 2) | {{WIDTH{1'b0}}, dvd[WIDTH-1 -: 2]};
    dig = t >= d3 ? 2'd3 : t >= d2 ? 2'd2 : t >= d1 ? 2'd1 : 2'd0;
    sub = dig == 2'd3 ? d3 : dig == 2'd2 ? d2 : dig == 2'd1 ? d1 : '0;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = !en ? IDLE : (zero || fast) ? DONE : CALC;
      CALC: state_n = cnt == CW'(1) ? DONE : CALC;
      DONE: state_n = en ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= IDLE;
      dvd <= '0;
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
      r <= '0;
      cnt <= '0;
      quotient <= '0;
      div_zero <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && en) begin
        dvd <= dividend;
        d1 <= {2'b00, divisor};
        d2 <= {1'b0, divisor, 1'b0};
        d3 <= {2'b00, divisor} + {1'b0, divisor, 1'b0};
        // short-circuit results land directly in the output registers
        r <= (zero || fast) ? {2'b00, dividend} : '0;
        quotient <= zero ? '1 : '0;
        div_zero <= zero;
        cnt <= CW'(ITER);
      end else if (state == CALC) begin
        r <= t - sub;
        dvd <= dvd << 2;
        quotient <= {quotient[WIDTH-3:0], dig};
        cnt <= cnt - CW'(1);
      end
    end
  end
endmodule

// File: doc/radix4_divider.md
Name: radix4_divider

Overview:
- Iterative unsigned 32/32 divider that produces 2 quotient bits per cycle.
- It is the responder behind the EX-stage multiply/divide unit. That unit supplies operand magnitudes and a level-sensitive enable, and applies sign correction to the outputs itself.
- It returns quotient, remainder, a divide-by-zero flag and a done level, with the same 17-cycle budget the unit's cycle counter expects.

Parameters:
WIDTH, 32, operand/result width; must be even; iteration count ITER = WIDTH/2 (16) is derived, not overridable.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  pipeline flush; aborts any operation, same effect as rst on state
en  input  1  level request; held high by requester while DIV/DIVU occupies EX
dividend  input  WIDTH  unsigned dividend magnitude, sampled only at start
divisor  input  WIDTH  unsigned divisor magnitude, sampled only at start
quotient  output  WIDTH  unsigned quotient, valid while done=1
remainder  output  WIDTH  unsigned remainder, valid while done=1
div_zero  output  1  divisor was zero, valid while done=1
busy  output  1  high in CALC state
done  output  1  high in DONE state

Behaviour:
- Reset (rst=1 or flush=1 at an edge):
  - State goes to IDLE.
  - quotient, remainder, div_zero, busy and done all go to 0; internal registers are cleared.
  - rst/flush win over every other event in the same cycle.
- States are IDLE, CALC and DONE.
- IDLE:
  - en=1 at an edge: latch the dividend into the shift register.
  - Latch D = divisor, D2 = 2D and D3 = 3D, each WIDTH+2 bits. Clear the partial remainder R (WIDTH+2 bits) and set iteration counter = ITER.
  - If divisor==0, go to DONE with div_zero=1, quotient = all ones and remainder = dividend. Otherwise go to CALC.
  - en=0: stay in IDLE.
- CALC, one radix-4 step per edge:
  - T = {R[WIDTH-1:0], top 2 dividend bits}.
  - Digit q = 3 if T>=D3, else 2 if T>=D2, else 1 if T>=D, else 0.
  - R <= T - q·D. Shift the dividend left by 2. Shift q into the quotient LSBs. Decrement the counter.
  - The step that takes the counter to 0 moves the state to DONE.
  - en is ignored during CALC; the operation completes even if en drops.
- Latency:
  - The first edge that samples en=1 is edge 0.
  - CALC runs on edges 1..16; done is high after edge 16, i.e. 17 cycles including the start cycle.
  - Divide-by-zero: done is high after edge 0.
- DONE:
  - Outputs are held stable; done=1.
  - en=1: stay in DONE. The requester holds en until its own counter releases, so back-to-back divides require en to drop for at least one cycle.
  - en=0: go to IDLE and drop done. Outputs keep their last values but are not valid.
- The remainder is R[WIDTH-1:0]. The invariant dividend = quotient·divisor + remainder with remainder < divisor must hold for all divisor≠0.
- A new start is never accepted from CALC or DONE; operands changing mid-operation have no effect.

Optional Feature:
DIV_FAST_PATH_EN:
- Defined: in IDLE with en=1 and divisor≠0, if dividend < divisor, go directly to DONE with quotient=0, remainder=dividend, div_zero=0. done is high after edge 0; CALC is skipped.
- Undefined: no comparison is made; every nonzero-divisor division takes the full 17 cycles.
- Either way, the requester's fixed counter remains correct because done stays high until en drops.

Test Plan:
- dividend=100, divisor=7, en held high → done rises after edge 16; quotient=14, remainder=2, div_zero=0; outputs stable until en drops, then done=0 next edge.
- dividend=0xFFFFFFFF, divisor=1 → quotient=0xFFFFFFFF, remainder=0. Then dividend=0xFFFFFFFF, divisor=0xFFFFFFFF → quotient=1, remainder=0.
- divisor=0, dividend=0x1234 → done after edge 0; div_zero=1, quotient=0xFFFFFFFF, remainder=0x1234.
- Start 0x80000000/3, assert flush at edge 8 → IDLE, done=0, busy=0 next edge. A fresh 9/2 afterwards → quotient=4, remainder=1 after 17 cycles.
- Drop en at edge 5 of 1000/10 → busy stays high, done rises after edge 16 with quotient=100, remainder=0; with en=0 the FSM goes IDLE the following edge.
- 5/9 with DIV_FAST_PATH_EN defined → done after edge 0, quotient=0, remainder=5. Undefined → same values after edge 16. Also cover 10000 random operand pairs checked against the invariant.
